// File: rtl/axioma_ptr_ldst.sv
// Indirect LD/ST/LDD/STD sequencer over the X/Y/Z pointers: accept, address, memory handshake, writeback.
// Four cycles minimum per command plus one per memory wait cycle; commands are refused while busy.
module axioma_ptr_ldst (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_store,
  input  logic [1:0]  cmd_ptr,
  input  logic [1:0]  cmd_mode,
  input  logic [5:0]  cmd_disp,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] x_pointer,
  input  logic [15:0] y_pointer,
  input  logic [15:0] z_pointer,
  output logic [4:0]  rs_addr,
  input  logic [7:0]  rs_data,
  output logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_write_en,
  output logic [15:0] ptr_out,
  output logic        x_write_en,
  output logic        y_write_en,
  output logic        z_write_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, ADDR, MEM, WB, ERR} state_t;

  state_t      state;
  logic        store_q;
  logic [1:0]  ptr_q;
  logic [1:0]  mode_q;
  logic [5:0]  disp_q;
  logic [4:0]  reg_q;
  logic [15:0] ptr_snap;

  logic [15:0] sel_ptr;
  logic        illegal;
  logic [15:0] ea;
  logic [15:0] ptr_next;
  logic        ptr_update;

  always_comb begin
    sel_ptr = z_pointer;
    case (cmd_ptr)
      2'd0:    sel_ptr = x_pointer;
      2'd1:    sel_ptr = y_pointer;
      default: sel_ptr = z_pointer;
    endcase
    // A load that also bumps its own pointer would write the same register twice.
    illegal = (cmd_ptr == 2'd3) ||
              (cmd_mode == 2'd3 && cmd_ptr == 2'd0) ||
              (!cmd_store && (cmd_mode == 2'd1 || cmd_mode == 2'd2) &&
               cmd_reg[4:1] == (4'd13 + {2'b00, cmd_ptr}));
    ea = ptr_snap;
    case (mode_q)
      2'd2:    ea = ptr_snap - 16'd1;
      2'd3:    ea = ptr_snap + {10'd0, disp_q};
      default: ea = ptr_snap;
    endcase
    ptr_next   = (mode_q == 2'd1) ? ptr_snap + 16'd1 : ptr_snap - 16'd1;
    ptr_update = (mode_q == 2'd1) || (mode_q == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      ptr_q       <= 2'd0;
      mode_q      <= 2'd0;
      disp_q      <= 6'd0;
      reg_q       <= 5'd0;
      ptr_snap    <= 16'd0;
      cmd_ready   <= 1'b0;
      rs_addr     <= 5'd0;
      rd_addr     <= 5'd0;
      rd_data     <= 8'd0;
      rd_write_en <= 1'b0;
      ptr_out     <= 16'd0;
      x_write_en  <= 1'b0;
      y_write_en  <= 1'b0;
      z_write_en  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rd_write_en <= 1'b0;
      x_write_en  <= 1'b0;
      y_write_en  <= 1'b0;
      z_write_en  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            store_q   <= cmd_store;
            ptr_q     <= cmd_ptr;
            mode_q    <= cmd_mode;
            disp_q    <= cmd_disp;
            reg_q     <= cmd_reg;
            ptr_snap  <= sel_ptr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (illegal) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state   <= ADDR;
              rs_addr <= cmd_reg;
            end
          end
        end
        ADDR: begin
          mem_addr  <= ea;
          mem_wdata <= rs_data;
          mem_we    <= store_q;
          mem_req   <= 1'b1;
          state     <= MEM;
        end
        MEM: begin
          if (mem_req && mem_ack) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            rd_data     <= mem_rdata;
            rd_addr     <= reg_q;
            rd_write_en <= !store_q;
            ptr_out     <= ptr_next;
            x_write_en  <= ptr_update && (ptr_q == 2'd0);
            y_write_en  <= ptr_update && (ptr_q == 2'd1);
            z_write_en  <= ptr_update && (ptr_q == 2'd2);
            done        <= 1'b1;
            state       <= WB;
          end
        end
        WB, ERR: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axioma_ptr_ldst.sv
// Scoreboard bench for axioma_ptr_ldst: a model predicts each command's memory access and writeback.
module tb_axioma_ptr_ldst;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [1:0]  cmd_ptr, cmd_mode;
  logic [5:0]  cmd_disp;
  logic [4:0]  cmd_reg;
  logic [15:0] x_pointer, y_pointer, z_pointer;
  logic [4:0]  rs_addr, rd_addr;
  logic [7:0]  rs_data, rd_data;
  logic        rd_write_en;
  logic [15:0] ptr_out;
  logic        x_write_en, y_write_en, z_write_en;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy, done, err;

  logic [7:0] regs [32];
  assign rs_data = regs[rs_addr];

  always #5 clk = ~clk;

  axioma_ptr_ldst dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_ptr(cmd_ptr), .cmd_mode(cmd_mode), .cmd_disp(cmd_disp), .cmd_reg(cmd_reg),
    .x_pointer(x_pointer), .y_pointer(y_pointer), .z_pointer(z_pointer),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
    .ptr_out(ptr_out), .x_write_en(x_write_en), .y_write_en(y_write_en), .z_write_en(z_write_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit          is_err;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          rd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [2:0]  pwe;
    logic [15:0] ptr_out;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int       mem_wait = 0;
  logic [7:0] mem_rd = 8'h00;
  bit       mem_auto = 1'b1;
  int       req_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after mem_wait cycles of an outstanding request.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) req_len++;
      if (mem_auto) begin
        if (!mem_req) begin
          mem_ack = 1'b0;
          cnt = 0;
        end else if (cnt == mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem_rd;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  // Output monitor: request fields against the head entry, strobes pop the head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (q.size() == 0) check("unexpected_req", {31'd0, mem_req}, 32'd0);
        else if (q[0].is_err) check("req_on_err", {31'd0, mem_req}, 32'd0);
        else begin
          check("mem_addr", {16'd0, mem_addr}, {16'd0, q[0].addr});
          check("mem_we", {31'd0, mem_we}, {31'd0, q[0].we});
          if (q[0].we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, q[0].wdata});
        end
      end
      if (done || err || rd_write_en || x_write_en || y_write_en || z_write_en) begin
        if (q.size() == 0) begin
          check("unexpected_strobe",
                {26'd0, done, err, rd_write_en, x_write_en, y_write_en, z_write_en}, 32'd0);
        end else begin
          e = q.pop_front();
          check("done", {31'd0, done}, {31'd0, !e.is_err});
          check("err", {31'd0, err}, {31'd0, e.is_err});
          check("rd_write_en", {31'd0, rd_write_en}, {31'd0, e.rd_en});
          if (e.rd_en) begin
            check("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd_addr});
            check("rd_data", {24'd0, rd_data}, {24'd0, e.rd_data});
          end
          check("ptr_we", {29'd0, z_write_en, y_write_en, x_write_en}, {29'd0, e.pwe});
          if (e.pwe != 3'b000) check("ptr_out", {16'd0, ptr_out}, {16'd0, e.ptr_out});
        end
      end
    end
  end

  task automatic run_cmd(input bit st, input logic [1:0] p, input logic [1:0] m,
                         input logic [5:0] d, input logic [4:0] rg, input int wt,
                         input logic [7:0] rdat, input bit perturb);
    exp_t e;
    logic [15:0] sel;
    int n;
    int k;
    sel = (p == 2'd0) ? x_pointer : (p == 2'd1) ? y_pointer : z_pointer;
    e.is_err = (p == 2'd3) || (m == 2'd3 && p == 2'd0) ||
               (!st && (m == 2'd1 || m == 2'd2) && rg[4:1] == 4'd13 + {2'b00, p});
    e.we = st;
    e.addr = (m == 2'd2) ? sel - 16'd1 : (m == 2'd3) ? sel + {10'd0, d} : sel;
    e.wdata = regs[rg];
    e.rd_en = !st && !e.is_err;
    e.rd_addr = rg;
    e.rd_data = rdat;
    e.pwe = (!e.is_err && (m == 2'd1 || m == 2'd2)) ? (3'b001 << p) : 3'b000;
    e.ptr_out = (m == 2'd1) ? sel + 16'd1 : sel - 16'd1;
    e.lat = e.is_err ? 1 : 3 + wt;
    mem_wait = wt;
    mem_rd = rdat;
    q.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = st; cmd_ptr = p; cmd_mode = m; cmd_disp = d; cmd_reg = rg;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    req_len = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    check("busy", {31'd0, busy}, 32'd1);
    check("ready_low", {31'd0, cmd_ready}, 32'd0);
    if (perturb) z_pointer = ~z_pointer;
    while (!(done || err) && n < 60) begin
      @(negedge clk);
      n++;
      if (perturb && n == 2) regs[rg] = ~regs[rg];
    end
    check("latency", n, e.lat);
    check("req_cycles", req_len, e.is_err ? 0 : wt + 1);
    @(negedge clk);
    check("ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'(i * 7 + 1);
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_ptr = 2'd0; cmd_mode = 2'd0;
    cmd_disp = 6'd0; cmd_reg = 5'd0;
    x_pointer = 16'h0000; y_pointer = 16'h0000; z_pointer = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_strobes", {28'd0, done, err, rd_write_en, x_write_en}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    y_pointer = 16'h01FF;
    run_cmd(1'b0, 2'd1, 2'd1, 6'd0, 5'd5, 0, 8'hA5, 1'b0);

    x_pointer = 16'h0000; regs[17] = 8'h3C;
    run_cmd(1'b1, 2'd0, 2'd2, 6'd0, 5'd17, 0, 8'h00, 1'b0);

    z_pointer = 16'h0100;
    run_cmd(1'b0, 2'd2, 2'd3, 6'd63, 5'd3, 3, 8'h5A, 1'b0);

    run_cmd(1'b0, 2'd3, 2'd0, 6'd0, 5'd4, 0, 8'h11, 1'b0);
    run_cmd(1'b0, 2'd0, 2'd3, 6'd4, 5'd4, 0, 8'h11, 1'b0);
    run_cmd(1'b0, 2'd0, 2'd1, 6'd0, 5'd26, 0, 8'h11, 1'b0);

    x_pointer = 16'hFFFF;
    run_cmd(1'b1, 2'd0, 2'd1, 6'd0, 5'd26, 1, 8'h00, 1'b0);
    y_pointer = 16'h1234;
    run_cmd(1'b0, 2'd1, 2'd0, 6'd0, 5'd29, 2, 8'hC3, 1'b0);

    z_pointer = 16'h2000; regs[9] = 8'h77;
    run_cmd(1'b1, 2'd2, 2'd3, 6'd5, 5'd9, 1, 8'h00, 1'b1);

    // Reset while a request is outstanding; a late ack must do nothing.
    mem_auto = 1'b0;
    mem_ack = 1'b0;
    z_pointer = 16'h0400;
    begin
      exp_t e;
      e.is_err = 0; e.we = 0; e.addr = 16'h0400; e.wdata = 8'h00; e.rd_en = 1;
      e.rd_addr = 5'd2; e.rd_data = 8'h00; e.pwe = 3'b000; e.ptr_out = 16'h0; e.lat = 3;
      q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_ptr = 2'd2; cmd_mode = 2'd0; cmd_reg = 5'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_req_high", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    q.delete();
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_strobes",
          {26'd0, done, err, rd_write_en, x_write_en, y_write_en, z_write_en}, 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    repeat (2) @(negedge clk);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    mem_ack = 1'b0;
    mem_auto = 1'b1;
    @(negedge clk);

    z_pointer = 16'h0401;
    run_cmd(1'b0, 2'd2, 2'd2, 6'd0, 5'd2, 0, 8'h96, 1'b0);

    for (int i = 0; i < 10; i++) begin
      x_pointer = 16'($urandom);
      y_pointer = 16'($urandom);
      z_pointer = 16'($urandom);
      regs[i + 10] = 8'($urandom);
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), $urandom_range(0, 2),
              8'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axioma_ptr_ldst.md
# axioma_ptr_ldst

Indirect load/store sequencer for the AxiomaCore-328 datapath. It executes AVR LD/ST/LDD/STD through the X, Y and Z pointer registers. It reads the pointer pair and the source register from the general-purpose register bank, computes the effective address, runs a request/acknowledge transaction on the data-memory bus, then writes back loaded data and any updated pointer. It sits between the instruction decoder and the register bank's write and pointer-write ports.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  decoder presents a command
- cmd_ready  out  1  block accepts a command (IDLE only)
- cmd_store  in  1  1 = ST/STD, 0 = LD/LDD
- cmd_ptr  in  2  0 = X, 1 = Y, 2 = Z, 3 = illegal
- cmd_mode  in  2  0 = plain, 1 = post-increment, 2 = pre-decrement, 3 = displacement
- cmd_disp  in  6  displacement q (0–63), used only in mode 3
- cmd_reg  in  5  Rd (load destination) or Rr (store source)
- x_pointer, y_pointer, z_pointer  in  16 each  current pointer values from the register bank
- rs_addr  out  5  source-register read address (store data)
- rs_data  in  8  source-register read data
- rd_addr  out  5  load destination address
- rd_data  out  8  load write data
- rd_write_en  out  1  load write strobe
- ptr_out  out  16  updated pointer value
- x_write_en, y_write_en, z_write_en  out  1 each  pointer write strobes
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  16  effective address
- mem_wdata  out  8  store data
- mem_ack  in  1  memory completes the request
- mem_rdata  in  8  load data, valid with mem_ack
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on completion
- err  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, ADDR, MEM, WB, ERR. All outputs are registered.
- **Reset** forces IDLE and clears every output to 0. cmd_ready is 0 during the reset cycle and 1 from the first IDLE cycle after it.
- **IDLE:** cmd_ready = 1. On a cycle with cmd_valid & cmd_ready, the block latches the cmd_* fields and a snapshot of the selected pointer.
  - Illegal command goes to ERR. Illegal means any of: cmd_ptr = 3; mode 3 with X; mode 1 or 2 on a load whose cmd_reg is a byte of the selected pointer (R26/27 for X, R28/29 for Y, R30/31 for Z).
  - Otherwise go to ADDR.
- **ADDR:** rs_addr = cmd_reg. Compute the 16-bit effective address (EA), modulo 2^16:
  - modes 0 and 1: EA = ptr
  - mode 2: EA = ptr − 1
  - mode 3: EA = ptr + zero-extended q
  - Latch EA, and rs_data as store data. Go to MEM.
- **MEM:** mem_req = 1, with mem_we, mem_addr and mem_wdata constant for the whole request. mem_ack is honoured only while mem_req = 1. On ack, capture mem_rdata and go to WB.
- **WB:**
  - Load: rd_write_en = 1, rd_addr = cmd_reg, rd_data = captured byte.
  - Mode 1: ptr_out = ptr + 1 (0xFFFF wraps to 0x0000).
  - Mode 2: ptr_out = ptr − 1 (0x0000 wraps to 0xFFFF).
  - In modes 1 and 2, the selected pointer's write_en = 1 in the same cycle as any load write. Modes 0 and 3 write no pointer.
  - done = 1. Go to IDLE.
- **ERR:** err = 1 for one cycle, with no memory access and no writeback. Go to IDLE.
- **Snapshots:** pointer and store data are used as captured. Register-bank changes after capture have no effect on the operation in flight.
- **Reset mid-operation:** the operation is abandoned. mem_req, the strobes, done and busy are all 0 the next cycle, and no writeback occurs.

## Timing
- Let cycle 0 be the accept cycle. ADDR is cycle 1. mem_req rises at the edge ending cycle 1, so it is high in cycle 2.
- Zero-wait memory (mem_ack high in cycle 2) gives WB/done in cycle 3 and cmd_ready = 1 in cycle 4. Minimum throughput is one command per 4 cycles.
- Each cycle of mem_ack delay adds one cycle. mem_req may stay high indefinitely.
- Rejected command: err in cycle 1, cmd_ready = 1 in cycle 2.
- Strobes (rd_write_en, x/y/z_write_en, done, err) are exactly one cycle wide.

## Test plan
- **LD post-increment:** Y = 0x01FF, LD R5 ← Y+, memory returns 0xA5 with zero wait → mem_addr 0x01FF in cycle 2; cycle 3 has rd_write_en (R5 = 0xA5), y_write_en with ptr_out 0x0200, and done.
- **ST pre-decrement with wrap:** X = 0x0000, R17 = 0x3C, ST −X ← R17 → mem_we = 1, mem_addr 0xFFFF, mem_wdata 0x3C; WB has ptr_out 0xFFFF, x_write_en, and no rd_write_en.
- **LDD displacement with wait states:** Z = 0x0100, q = 63, mem_ack delayed 3 cycles → mem_addr 0x013F held stable for 4 cycles; done in cycle 6; no pointer write.
- **Illegal commands** (cmd_ptr = 3; LDD via X; LD R26 ← X+) → err pulse in cycle 1, mem_req never asserted, no strobes, cmd_ready in cycle 2.
- **Reset mid-operation:** reset asserted in cycle 2 while mem_req is high and mem_ack is low → all outputs 0 the next cycle; a later mem_ack is ignored; the next command executes normally.
- **Snapshot isolation:** change z_pointer and rs_data after the accept cycle → EA and store data reflect the captured values.
